// File: rtl/video_port_responder_pkg.sv
// Shared definitions for the video fetch port responder:
// bandwidth codes, FSM state codes, counter widths and slot ownership decode.
package video_port_responder_pkg;

    localparam int SLOT_W  = 3;
    localparam int OUTST_W = 2;

    typedef enum logic [1:0] {
        VBW_1_8 = 2'b00,
        VBW_1_4 = 2'b01,
        VBW_1_2 = 2'b10,
        VBW_ALL = 2'b11
    } vbw_e;

    typedef enum logic [1:0] {
        VPS_IDLE   = 2'b00,
        VPS_ACTIVE = 2'b01,
        VPS_DRAIN  = 2'b10
    } vps_e;

    // True when the given slot number belongs to video at bandwidth bw.
    function automatic logic own_slot(
        input logic [1:0]        bw,
        input logic [SLOT_W-1:0] slot
    );
        logic own;
        own = 1'b0;
        unique case (vbw_e'(bw))
            VBW_1_8: own = (slot == '0);
            VBW_1_4: own = (slot[1:0] == 2'b00);
            VBW_1_2: own = ~slot[0];
            VBW_ALL: own = 1'b1;
        endcase
        return own;
    endfunction

endpackage

// File: rtl/video_port_responder_slot_sched.sv
// Slot scheduler: 3-bit slot counter advanced at every cend, plus the
// ownership decode for the slot that starts at the next cend.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   cend_i          slot boundary pulse (counter advances)
//   pre_cend_i      decision pulse, one clk before cend
//   restart_i       force the upcoming slot to be slot 0 (valid at pre_cend)
//   bw_i            video bandwidth code
//   slot_nz_o       current slot is not slot 0 (VIDPORT_CHECK_EN builds only)
//   own_next_o      upcoming slot belongs to video
module video_port_responder_slot_sched
    import video_port_responder_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cend_i,
    input  logic       pre_cend_i,
    input  logic       restart_i,
    input  logic [1:0] bw_i,
`ifdef VIDPORT_CHECK_EN
    output logic       slot_nz_o,
`endif
    output logic       own_next_o
);

    logic [SLOT_W-1:0] cnt_q;
    logic [SLOT_W-1:0] cnt_d;
    logic [SLOT_W-1:0] next_slot;

    // Restart loads all-ones so the increment at the coming cend lands on 0.
    always_comb begin
        cnt_d = cnt_q;
        if (pre_cend_i && restart_i) begin
            cnt_d = '1;
        end else if (cend_i) begin
            cnt_d = cnt_q + SLOT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign next_slot  = restart_i ? '0 : cnt_q + SLOT_W'(1);
    assign own_next_o = own_slot(bw_i, next_slot);

`ifdef VIDPORT_CHECK_EN
    assign slot_nz_o = (cnt_q != '0);
`endif

endmodule

// File: rtl/video_port_responder.sv
// Arbiter-side responder for the video fetch port: grants DRAM slots to
// video reads at the requested bandwidth and returns read data in order.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   cend, pre_cend        slot boundary and the pulse one clk before it
//   video_go/bw/addr      fetch chain request, bandwidth, next word address
//   video_next            address consumed (pulse in the granted cend clk)
//   video_strobe/data     returned word, strobe one clk after dram_vrdy
//   dram_vid/addr         current slot owned by video and its address
//   dram_vrdy/rdata       DRAM engine read completion and data
//   cpu_slot              current slot free for CPU/DMA
//   err                   sticky protocol error, live only with VIDPORT_CHECK_EN
module video_port_responder
    import video_port_responder_pkg::*;
#(
    parameter int MAX_OUTST = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cend,
    input  logic        pre_cend,
    input  logic        video_go,
    input  logic [1:0]  video_bw,
    input  logic [20:0] video_addr,
    output logic        video_next,
    output logic        video_strobe,
    output logic [15:0] video_data,
    output logic        dram_vid,
    output logic [20:0] dram_addr,
    input  logic        dram_vrdy,
    input  logic [15:0] dram_rdata,
    output logic        cpu_slot,
    output logic        err
);

    vps_e               state_q;
    vps_e               state_d;
    logic               restart;
    logic               own_next;
    logic               room;
    logic               grant_q;
    logic               grant_d;
    logic               issue;
    logic               ret;
    logic [OUTST_W-1:0] outst_q;
    logic [OUTST_W-1:0] outst_d;
    logic               vid_q;
    logic               cpu_q;
    logic [20:0]        addr_q;
    logic               strobe_q;
    logic [15:0]        data_q;
`ifdef VIDPORT_CHECK_EN
    logic               slot_nz;
`endif

    video_port_responder_slot_sched u_sched (
        .clk        (clk),
        .rst_n      (rst_n),
        .cend_i     (cend),
        .pre_cend_i (pre_cend),
        .restart_i  (restart),
        .bw_i       (video_bw),
`ifdef VIDPORT_CHECK_EN
        .slot_nz_o  (slot_nz),
`endif
        .own_next_o (own_next)
    );

    assign room  = (outst_q < OUTST_W'(MAX_OUTST));
    assign issue = cend & grant_q;
    // Completions with nothing outstanding are stale and dropped.
    assign ret   = dram_vrdy & (outst_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= VPS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (pre_cend) begin
            unique case (state_q)
                VPS_IDLE: begin
                    if (video_go) begin
                        state_d = VPS_ACTIVE;
                        restart = 1'b1;
                    end
                end
                VPS_ACTIVE: begin
                    if (!video_go) begin
                        state_d = (outst_q != '0) ? VPS_DRAIN
                                                  : VPS_IDLE;
                    end
                end
                VPS_DRAIN: begin
                    if (video_go) begin
                        state_d = VPS_ACTIVE;
                    end else if (outst_q == '0) begin
                        state_d = VPS_IDLE;
                    end
                end
                default: state_d = VPS_IDLE;
            endcase
        end
    end

    // Grant is decided at pre_cend and consumed at the following cend.
    always_comb begin
        grant_d = grant_q;
        if (cend) begin
            grant_d = 1'b0;
        end
        if (pre_cend) begin
            grant_d = (state_d == VPS_ACTIVE) & video_go
                    & own_next & room;
        end
    end

    always_comb begin
        outst_d = outst_q;
        case ({issue, ret})
            2'b10:   outst_d = outst_q + OUTST_W'(1);
            2'b01:   outst_d = outst_q - OUTST_W'(1);
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_q  <= 1'b0;
            outst_q  <= '0;
            vid_q    <= 1'b0;
            cpu_q    <= 1'b0;
            addr_q   <= '0;
            strobe_q <= 1'b0;
            data_q   <= '0;
        end else begin
            grant_q  <= grant_d;
            outst_q  <= outst_d;
            strobe_q <= ret;
            if (ret) begin
                data_q <= dram_rdata;
            end
            if (cend) begin
                vid_q <= grant_q;
                cpu_q <= ~grant_q;
                if (grant_q) begin
                    addr_q <= video_addr;
                end
            end
        end
    end

    assign video_next   = issue;
    assign video_strobe = strobe_q;
    assign video_data   = data_q;
    assign dram_vid     = vid_q;
    assign dram_addr    = addr_q;
    assign cpu_slot     = cpu_q;

`ifdef VIDPORT_CHECK_EN
    logic       err_q;
    logic [1:0] bw_q;
    logic       bw_err;

    assign bw_err = pre_cend & (state_q == VPS_ACTIVE)
                  & slot_nz & (video_bw != bw_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            bw_q  <= '0;
        end else begin
            if (pre_cend) begin
                bw_q <= video_bw;
            end
            if ((dram_vrdy && outst_q == '0) || bw_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_video_port_responder.sv
// Directed bench for video_port_responder: table of bandwidth scenarios
// plus hand sequences for backpressure, drain, reset and restart.
`timescale 1ns/1ps
module tb_video_port_responder;

    localparam logic [20:0] ADDR_BASE = 21'h10000;
`ifdef VIDPORT_CHECK_EN
    localparam int EXP_ERR = 1;
`else
    localparam int EXP_ERR = 0;
`endif

    logic        clk;
    logic        rst_n;
    logic        cend;
    logic        pre_cend;
    logic        video_go;
    logic [1:0]  video_bw;
    logic [20:0] video_addr;
    logic        video_next;
    logic        video_strobe;
    logic [15:0] video_data;
    logic        dram_vid;
    logic [20:0] dram_addr;
    logic        dram_vrdy;
    logic [15:0] dram_rdata;
    logic        cpu_slot;
    logic        err;

    video_port_responder #(.MAX_OUTST(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cend         (cend),
        .pre_cend     (pre_cend),
        .video_go     (video_go),
        .video_bw     (video_bw),
        .video_addr   (video_addr),
        .video_next   (video_next),
        .video_strobe (video_strobe),
        .video_data   (video_data),
        .dram_vid     (dram_vid),
        .dram_addr    (dram_addr),
        .dram_vrdy    (dram_vrdy),
        .dram_rdata   (dram_rdata),
        .cpu_slot     (cpu_slot),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] bw;
        logic       go;
        logic       autor;
        int         nslots;
        int         exp_next;
        int         exp_cpu;
        int         exp_strobe;
    } row_t;

    row_t rows[6];

    int          n_chk;
    int          n_fail;
    int          cyc;
    logic [1:0]  ph;
    logic        auto_vrdy;
    int          next_cyc;
    int          vcount;
    int          n_next_tot;
    int          n_strobe_tot;
    int          n_cpu_tot;
    int          n_vid_tot;
    logic [20:0] exp_addr;
    logic        addr_pend;
    int          s_next;
    int          s_strobe;
    int          s_cpu;
    int          s_vid;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic sample();
        if (video_next) begin
            n_next_tot++;
            next_cyc  = cyc;
            exp_addr  = video_addr;
            addr_pend = 1'b1;
        end
        if (video_strobe) begin
            if (n_strobe_tot < vcount) begin
                check("strobe_data", 32'(video_data),
                      32'(16'hC000 + n_strobe_tot[15:0]));
            end else begin
                check("strobe_unexpected", 32'(video_strobe), 32'd0);
            end
            n_strobe_tot++;
        end
        if (ph == 2'd2) begin
            if (cpu_slot) n_cpu_tot++;
            if (dram_vid) begin
                n_vid_tot++;
                if (addr_pend) begin
                    check("dram_addr", 32'(dram_addr), 32'(exp_addr));
                    addr_pend = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        ph         = ph + 2'd1;
        cend       = (ph == 2'd0);
        pre_cend   = (ph == 2'd3);
        video_addr = ADDR_BASE + 21'(n_next_tot);
        dram_vrdy  = 1'b0;
        dram_rdata = 16'h0;
        if (auto_vrdy && next_cyc == cyc - 2) begin
            dram_vrdy  = 1'b1;
            dram_rdata = 16'hC000 + 16'(vcount);
            vcount++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic to_phase3();
        for (int i = 0; i < 4 && ph != 2'd3; i++) tick();
    endtask

    task automatic pulse_vrdy();
        dram_vrdy  = 1'b1;
        dram_rdata = 16'hC000 + 16'(vcount);
        vcount++;
    endtask

    task automatic snap();
        s_next   = n_next_tot;
        s_strobe = n_strobe_tot;
        s_cpu    = n_cpu_tot;
        s_vid    = n_vid_tot;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        video_go  = 1'b0;
        video_bw  = 2'b00;
        auto_vrdy = 1'b0;
        run(3);
        rst_n     = 1'b1;
        addr_pend = 1'b0;
        next_cyc  = -100;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_next"}, 32'(video_next), 32'd0);
        check({tag, "_strobe"}, 32'(video_strobe), 32'd0);
        check({tag, "_data"}, 32'(video_data), 32'd0);
        check({tag, "_vid"}, 32'(dram_vid), 32'd0);
        check({tag, "_addr"}, 32'(dram_addr), 32'd0);
        check({tag, "_cpu"}, 32'(cpu_slot), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; ph = 2'd0;
        vcount = 0; next_cyc = -100; addr_pend = 1'b0;
        n_next_tot = 0; n_strobe_tot = 0;
        n_cpu_tot = 0; n_vid_tot = 0; exp_addr = '0;
        rst_n = 1'b0; cend = 1'b1; pre_cend = 1'b0;
        video_go = 1'b0; video_bw = 2'b00; auto_vrdy = 1'b0;
        video_addr = ADDR_BASE; dram_vrdy = 1'b0; dram_rdata = '0;

        //           bw     go    auto  slots next cpu strobe
        rows[0] = '{2'b01, 1'b1, 1'b1, 16, 4,  12, 4};
        rows[1] = '{2'b00, 1'b1, 1'b1, 32, 4,  28, 4};
        rows[2] = '{2'b11, 1'b1, 1'b1, 32, 32, 0,  32};
        rows[3] = '{2'b10, 1'b1, 1'b1, 16, 8,  8,  8};
        rows[4] = '{2'b11, 1'b1, 1'b0, 8,  2,  6,  0};
        rows[5] = '{2'b11, 1'b0, 1'b1, 8,  0,  8,  0};

        do_reset();
        check_reset("reset");

        for (int r = 0; r < 6; r++) begin
            do_reset();
            to_phase3();
            video_bw  = rows[r].bw;
            video_go  = rows[r].go;
            auto_vrdy = rows[r].autor;
            snap();
            run(4 * rows[r].nslots);
            video_go = 1'b0;
            check($sformatf("row%0d_next", r),
                  32'(n_next_tot - s_next), 32'(rows[r].exp_next));
            check($sformatf("row%0d_vid", r),
                  32'(n_vid_tot - s_vid), 32'(rows[r].exp_next));
            check($sformatf("row%0d_cpu", r),
                  32'(n_cpu_tot - s_cpu), 32'(rows[r].exp_cpu));
            run(12);
            check($sformatf("row%0d_strobe", r),
                  32'(n_strobe_tot - s_strobe), 32'(rows[r].exp_strobe));
            check($sformatf("row%0d_err", r), 32'(err), 32'd0);
        end

        // Backpressure: two outstanding, then a return and a
        // grant+return in the same clk leave room for exactly one more.
        do_reset();
        to_phase3();
        video_bw = 2'b11;
        video_go = 1'b1;
        snap();
        run(14);
        pulse_vrdy();
        run(3);
        pulse_vrdy();
        run(12);
        check("bp_next", 32'(n_next_tot - s_next), 32'd4);
        check("bp_strobe", 32'(n_strobe_tot - s_strobe), 32'd2);
        check("bp_cpu", 32'(n_cpu_tot - s_cpu), 32'd3);

        // Drain: go drops with two outstanding; then restart from IDLE
        // must land on slot 0 again.
        do_reset();
        to_phase3();
        video_bw = 2'b11;
        video_go = 1'b1;
        run(8);
        video_go = 1'b0;
        snap();
        run(2);
        pulse_vrdy();
        run(2);
        pulse_vrdy();
        run(8);
        check("drain_next", 32'(n_next_tot - s_next), 32'd0);
        check("drain_strobe", 32'(n_strobe_tot - s_strobe), 32'd2);
        video_bw = 2'b00;
        video_go = 1'b1;
        snap();
        run(4);
        check("restart_next", 32'(n_next_tot - s_next), 32'd1);
        check("restart_vid", 32'(n_vid_tot - s_vid), 32'd1);
        video_go = 1'b0;
        run(8);

        // Reset with one read in flight, then a stray completion.
        do_reset();
        to_phase3();
        video_bw = 2'b11;
        video_go = 1'b1;
        run(2);
        rst_n    = 1'b0;
        video_go = 1'b0;
        run(2);
        rst_n = 1'b1;
        check_reset("midrst");
        snap();
        run(1);
        dram_vrdy  = 1'b1;
        dram_rdata = 16'hDEAD;
        run(4);
        check("stray_strobe", 32'(n_strobe_tot - s_strobe), 32'd0);
        check("stray_data", 32'(video_data), 32'd0);
        check("stray_err", 32'(err), 32'(EXP_ERR));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
